// File: rtl/ttl_mux_scan.sv
// ttl_mux_scan: registered N:1 data selector with a channel-scanning pointer
// and a valid/ready holding register on the output. This is the clocked
// successor to the 8-input TTL selector. The pointer can be loaded directly
// from S or stepped once per captured sample. The holding register lets a
// single downstream consumer throttle how fast channels are sampled.

module ttl_mux_scan #(
    parameter int WIDTH    = 1,
    parameter int CHANNELS = 8,
    parameter int SEL_BITS = 3,
    parameter int START    = 0
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [CHANNELS*WIDTH-1:0] In,
    input  logic [SEL_BITS-1:0]       S,
    input  logic                      Load,
    input  logic                      Scan,
    input  logic                      G_n,
    input  logic                      Ready,
    output logic [WIDTH-1:0]          Out,
    output logic [WIDTH-1:0]          Out_n,
    output logic [SEL_BITS-1:0]       Chan,
    output logic                      Valid,
    output logic                      Wrap
);

    // Every value the pointer field can encode gets a slot in the channel
    // table. Slots at or above CHANNELS read as zero. The pointer never
    // reaches them, because loads are range-checked and the scan wraps early.
    localparam int SLOTS = 1 << SEL_BITS;

    // The channel count is held one bit wider than the pointer. This lets
    // CHANNELS == 2^SEL_BITS be compared against S without overflow.
    localparam logic [SEL_BITS:0]   CHAN_COUNT = (SEL_BITS + 1)'(CHANNELS);
    localparam logic [SEL_BITS-1:0] LAST_CHAN  = SEL_BITS'(CHANNELS - 1);
    localparam logic [SEL_BITS-1:0] START_CHAN = SEL_BITS'(START);

    logic [SEL_BITS-1:0] ptr;
    logic [WIDTH-1:0]    chan_data [SLOTS];
    logic [WIDTH-1:0]    selected;

    logic free;
    logic capture;
    logic load_in_range;
    logic at_last;
    logic step;
    logic [SEL_BITS-1:0] ptr_plus_one;

    // Split the flat input bus into one entry per pointer value. Unused
    // entries are tied to zero, so the selector below is a plain array index.
    for (genvar k = 0; k < SLOTS; k++) begin : g_slot
        if (k < CHANNELS) begin : g_used
            assign chan_data[k] = In[k*WIDTH +: WIDTH];
        end else begin : g_unused
            assign chan_data[k] = '0;
        end
    end

    assign selected = chan_data[ptr];

    // The holding register can take a new sample when it is empty, or when
    // the consumer is draining it in this same cycle. The strobe then decides
    // whether a sample is actually taken.
    assign free    = !Valid || Ready;
    assign capture = free && !G_n;

    // Load has priority over scanning even when S is out of range. A rejected
    // load leaves the pointer where it is; it does not fall through to a scan
    // step.
    assign load_in_range = Load && ({1'b0, S} < CHAN_COUNT);
    assign at_last       = (ptr == LAST_CHAN);
    assign step          = !Load && capture && Scan;
    assign ptr_plus_one  = at_last ? '0 : ptr + 1'b1;

    // Pointer register: a direct load wins, otherwise step after each capture
    // while scanning.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr <= START_CHAN;
        end else if (load_in_range) begin
            ptr <= S;
        end else if (step) begin
            ptr <= ptr_plus_one;
        end
    end

    // Output holding register: capture when free and strobed, go empty when
    // free but not strobed, freeze while the consumer stalls. On a capture,
    // Chan records the pointer value used before any same-cycle load lands.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out   <= '0;
            Chan  <= '0;
            Valid <= 1'b0;
        end else if (capture) begin
            Out   <= selected;
            Chan  <= ptr;
            Valid <= 1'b1;
        end else if (free) begin
            Valid <= 1'b0;
        end
    end

    // Wrap pulses only when a scan step rolls the pointer over. A load to
    // zero never sets it, because step is suppressed whenever Load is high.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Wrap <= 1'b0;
        end else begin
            Wrap <= step && at_last;
        end
    end

    assign Out_n = ~Out;

endmodule

// File: tb/tb_ttl_mux_scan.sv
// Bench for ttl_mux_scan. Two instances share the control inputs:
//   - an 8-channel unit with START=0;
//   - a 5-channel unit with START=2, for the boundary cases.
// Only one unit is out of reset at a time. Expected samples are queued as
// stimulus is issued. A forked monitor per unit pops and compares on every
// Valid && Ready handshake.

module tb_ttl_mux_scan;

    logic        clk = 1'b0;
    logic        reset_a;
    logic        reset_b;
    logic [31:0] in_a;
    logic [19:0] in_b;
    logic [2:0]  s;
    logic        load;
    logic        scan;
    logic        g_n;
    logic        ready;

    logic [3:0]  out_a;
    logic [3:0]  out_n_a;
    logic [2:0]  chan_a;
    logic        valid_a;
    logic        wrap_a;

    logic [3:0]  out_b;
    logic [3:0]  out_n_b;
    logic [2:0]  chan_b;
    logic        valid_b;
    logic        wrap_b;

    typedef struct packed {
        logic [2:0] chan;
        logic [3:0] data;
        logic       wrap;
    } sample_t;

    sample_t qa[$];
    sample_t qb[$];

    int checks = 0;
    int errors = 0;

    // Channel k of unit A carries k+3. Channel k of unit B carries 2k+1.
    localparam logic [31:0] IN_A_PATTERN = 32'hA987_6543;
    localparam logic [31:0] IN_A_SCRAMBLE = 32'h0F0F_0F0F;
    localparam logic [19:0] IN_B_PATTERN = 20'h97531;

    // Free-running clock.
    always #5 clk = ~clk;

    ttl_mux_scan #(
        .WIDTH(4), .CHANNELS(8), .SEL_BITS(3), .START(0)
    ) dut_a (
        .Clk(clk), .Reset(reset_a), .In(in_a), .S(s), .Load(load),
        .Scan(scan), .G_n(g_n), .Ready(ready), .Out(out_a),
        .Out_n(out_n_a), .Chan(chan_a), .Valid(valid_a), .Wrap(wrap_a)
    );

    ttl_mux_scan #(
        .WIDTH(4), .CHANNELS(5), .SEL_BITS(3), .START(2)
    ) dut_b (
        .Clk(clk), .Reset(reset_b), .In(in_b), .S(s), .Load(load),
        .Scan(scan), .G_n(g_n), .Ready(ready), .Out(out_b),
        .Out_n(out_n_b), .Chan(chan_b), .Valid(valid_b), .Wrap(wrap_b)
    );

    // Sets up the inputs for the next rising edge. Inputs change just after
    // an edge so they are stable across the following one.
    task automatic applyStimulus(input logic gn_v, input logic ready_v,
                                 input logic scan_v, input logic load_v,
                                 input logic [2:0] s_v);
        @(posedge clk);
        #1;
        g_n   = gn_v;
        ready = ready_v;
        scan  = scan_v;
        load  = load_v;
        s     = s_v;
    endtask

    task automatic pushExp(input bit use_b, input int ch, input int d, input bit w);
        sample_t e;
        e.chan = 3'(ch);
        e.data = 4'(d);
        e.wrap = w;
        if (use_b) qb.push_back(e);
        else       qa.push_back(e);
    endtask

    // Direct check at the falling edge. It covers the state left by the
    // rising edge just before the most recent applyStimulus call.
    task automatic checkOutput(input bit use_b, input string name,
                               input logic v, input logic [2:0] c,
                               input logic [3:0] d, input logic w);
        logic       av;
        logic [2:0] ac;
        logic [3:0] ad;
        logic [3:0] adn;
        logic       aw;
        @(negedge clk);
        av  = use_b ? valid_b : valid_a;
        ac  = use_b ? chan_b  : chan_a;
        ad  = use_b ? out_b   : out_a;
        adn = use_b ? out_n_b : out_n_a;
        aw  = use_b ? wrap_b  : wrap_a;
        checks++;
        if (av !== v || ac !== c || ad !== d || adn !== ~d || aw !== w) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b chan=%0d out=%h out_n=%h wrap=%b, want valid=%b chan=%0d out=%h out_n=%h wrap=%b",
                     name, av, ac, ad, adn, aw, v, c, d, ~d, w);
        end
    endtask

    // Scoreboard monitor. Every sample handed to the consumer must match the
    // oldest queued expectation.
    task automatic monitorDut(input bit use_b);
        sample_t    e;
        logic       av;
        logic [2:0] ac;
        logic [3:0] ad;
        logic [3:0] adn;
        logic       aw;
        forever begin
            @(negedge clk);
            av  = use_b ? valid_b : valid_a;
            ac  = use_b ? chan_b  : chan_a;
            ad  = use_b ? out_b   : out_a;
            adn = use_b ? out_n_b : out_n_a;
            aw  = use_b ? wrap_b  : wrap_a;
            if (av === 1'b1 && ready === 1'b1) begin
                checks++;
                if ((use_b ? qb.size() : qa.size()) == 0) begin
                    errors++;
                    $display("[TB] FAIL %s unexpected sample: got chan=%0d out=%h, want no sample",
                             use_b ? "B" : "A", ac, ad);
                end else begin
                    e = use_b ? qb.pop_front() : qa.pop_front();
                    if (ac !== e.chan || ad !== e.data || adn !== ~e.data || aw !== e.wrap) begin
                        errors++;
                        $display("[TB] FAIL %s sample: got chan=%0d out=%h out_n=%h wrap=%b, want chan=%0d out=%h out_n=%h wrap=%b",
                                 use_b ? "B" : "A", ac, ad, adn, aw, e.chan, e.data, ~e.data, e.wrap);
                    end
                end
            end
        end
    endtask

    // Directed sequence: unit A first, then unit B.
    initial begin
        reset_a = 1'b1;
        reset_b = 1'b1;
        in_a    = IN_A_PATTERN;
        in_b    = IN_B_PATTERN;
        s       = 3'd0;
        load    = 1'b0;
        scan    = 1'b0;
        g_n     = 1'b1;
        ready   = 1'b1;

        fork
            monitorDut(1'b0);
            monitorDut(1'b1);
        join_none

        repeat (2) @(posedge clk);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput(1'b0, "A reset", 1'b0, 3'd0, 4'd0, 1'b0);

        // Full scan from reset: channels 0..7 then 0, wrapping on 7.
        for (int k = 0; k < 9; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            if (k == 0) reset_a = 1'b0;
            pushExp(1'b0, k % 8, (k % 8) + 3, (k % 8) == 7);
        end

        // Direct select of channel 5. The load cycle still samples the old
        // pointer, which is 1.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 3'd5);
        pushExp(1'b0, 1, 4, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
            pushExp(1'b0, 5, 8, 1'b0);
        end

        // Reload 0 while capturing channel 5; a load to 0 must not pulse Wrap.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        pushExp(1'b0, 5, 8, 1'b0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            pushExp(1'b0, k, k + 3, 1'b0);
        end

        // Backpressure at channel 2 for three cycles, with noise on In.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 3'd0);
            in_a = IN_A_SCRAMBLE;
            checkOutput(1'b0, "A stall hold", 1'b1, 3'd2, 4'd5, 1'b0);
        end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        in_a = IN_A_PATTERN;
        pushExp(1'b0, 3, 6, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        pushExp(1'b0, 4, 7, 1'b0);

        // Strobe off for two cycles: output empties and the pointer stays at 5.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 3'd0);
        checkOutput(1'b0, "A strobe idle 1", 1'b0, 3'd4, 4'd7, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        checkOutput(1'b0, "A strobe idle 2", 1'b0, 3'd4, 4'd7, 1'b0);
        pushExp(1'b0, 5, 8, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        pushExp(1'b0, 6, 9, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);

        // Hand over to unit B, which has been held in reset so far.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        reset_a = 1'b1;
        checkOutput(1'b1, "B reset", 1'b0, 3'd0, 4'd0, 1'b0);

        // Scan from START=2 across the wrap at 4: 2,3,4,0,1.
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            if (k == 0) reset_b = 1'b0;
            pushExp(1'b1, (k + 2) % 5, 2 * ((k + 2) % 5) + 1, ((k + 2) % 5) == 4);
        end

        // Out-of-range load of 6 with no strobe: the pointer must stay at 2.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 3'd6);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 3'd0);
        checkOutput(1'b1, "B load ignored idle", 1'b0, 3'd1, 4'd3, 1'b0);
        pushExp(1'b1, 2, 5, 1'b0);

        // Load together with capture: old pointer 2 is reported, then 4.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd4);
        pushExp(1'b1, 2, 5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        pushExp(1'b1, 4, 9, 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            pushExp(1'b1, k, 2 * k + 1, 1'b0);
        end

        // Load 0 while the pointer sits at 4: no Wrap pulse.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 3'd0);
        pushExp(1'b1, 4, 9, 1'b0);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
            pushExp(1'b1, k, 2 * k + 1, k == 4);
        end

        // Reset while channel 4 is on the output. Scanning restarts at START.
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        reset_b = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        reset_b = 1'b0;
        checkOutput(1'b1, "B mid-scan reset", 1'b0, 3'd0, 4'd0, 1'b0);
        pushExp(1'b1, 2, 5, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
        pushExp(1'b1, 3, 7, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        @(negedge clk);

        checks++;
        if (qa.size() != 0) begin
            errors++;
            $display("[TB] FAIL A leftover: %0d samples never delivered, want 0", qa.size());
        end
        checks++;
        if (qb.size() != 0) begin
            errors++;
            $display("[TB] FAIL B leftover: %0d samples never delivered, want 0", qb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ttl_mux_scan.md
# ttl_mux_scan

Parametrised, registered N:1 data selector with a built-in channel scanner and a valid/ready output stage. It is the clocked successor to the 8-input TTL selector. It generalises channel count and data width, adds a select-pointer register that is either loaded directly or auto-incremented, and adds an output holding register so a downstream consumer can throttle sampling. It sits between multi-source buses (register file read ports, I/O input latches) and single-consumer datapaths in the CPU.

## Interface
- `WIDTH`, 1: bits per channel.
- `CHANNELS`, 8: number of input channels, 2..256, need not be a power of two.
- `SEL_BITS`, 3: pointer width. Must satisfy 2^SEL_BITS >= CHANNELS.
- `START`, 0: pointer value after reset. Must be < CHANNELS.

- `Clk`  in  1  single clock; all state changes on rising edge.
- `Reset`  in  1  synchronous, active-high reset.
- `In`  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
- `S`  in  SEL_BITS  value loaded into the pointer when `Load`=1.
- `Load`  in  1  load pointer from `S`.
- `Scan`  in  1  1 = auto-increment pointer after each capture; 0 = pointer holds.
- `G_n`  in  1  active-low strobe/enable. 1 = no capture, no advance.
- `Ready`  in  1  consumer accepts `Out` this cycle when `Valid`=1.
- `Out`  out  WIDTH  registered selected data.
- `Out_n`  out  WIDTH  bitwise complement of `Out` (combinational from register).
- `Chan`  out  SEL_BITS  channel index that produced `Out`.
- `Valid`  out  1  `Out`/`Chan` hold an unconsumed sample.
- `Wrap`  out  1  one-cycle pulse: the scan advanced from CHANNELS-1 to 0.

## Operation
- State: `Ptr` (SEL_BITS), output register {`Out`, `Chan`, `Valid`}, `Wrap` flag.
- Reset: `Ptr`=START, `Out`=0, `Out_n`=all ones, `Chan`=0, `Valid`=0, `Wrap`=0. Reset overrides all other inputs.
- Free = !Valid | Ready.
- Capture = Free & !G_n. On capture: `Out` <= In[Ptr], `Chan` <= Ptr, `Valid` <= 1.
- No capture while Free: `Valid` <= 0, and `Out`/`Chan` hold their stale values.
- Not Free (Valid & !Ready): output register holds, including `Valid`.
- Pointer update, in priority order:
  - `Load`: Ptr <= S if S < CHANNELS. Otherwise Ptr holds (out-of-range load ignored).
  - Otherwise Capture & Scan: Ptr <= (Ptr == CHANNELS-1) ? 0 : Ptr+1.
  - Otherwise Ptr holds.
- `Load` is not gated by `G_n` or `Ready`.
- Same-cycle Load and Capture: the capture uses the old Ptr, and Ptr takes S.
- `Wrap` <= 1 only in a cycle where a scan increment takes Ptr from CHANNELS-1 to 0. It is 0 in all other cycles. A Load to 0 does not set `Wrap`.
- `Scan`=0 with continuous Capture resamples the same channel every cycle.

## Timing
- In-to-Out latency is 1 clock: data present at edge n appears on `Out` after edge n.
- Throughput: 1 sample/clock when Ready=1 continuously.
- `Ptr` is visible only via `Chan`. A loaded S is first reported on `Chan` after edge n+1 (load at edge n, capture at edge n+1).
- Full scan of CHANNELS channels with Ready=1 and G_n=0 takes CHANNELS clocks. `Wrap` is asserted coincident with `Chan`=CHANNELS-1 on the output.
- Backpressure: while Valid=1 and Ready=0, `Out`, `Chan`, `Valid` and `Ptr` (unless loaded) are frozen, and `In` changes are ignored.
- Reset asserted mid-scan: state returns to the reset values on that edge. The first capture after reset deasserts samples channel START.

## Test plan
- Reset then scan: CHANNELS=8, WIDTH=4, channel k driven with k+3, Scan=1, G_n=0, Ready=1. Required: `Chan` sequence 0..7,0 with `Out` 3..10,3. `Wrap`=1 only in the cycle `Chan`=7. `Out_n`=~`Out`.
- Direct select: Scan=0, Load=1 with S=5 for one cycle. Required: next capture gives `Chan`=5, `Out`=In[5], and `Chan` stays 5 on subsequent cycles.
- Backpressure: during a scan, drop Ready for 3 cycles at `Chan`=2. Required: `Out`/`Chan`/`Valid` frozen at channel 2. After Ready rises, the next sample is channel 3, with no channel skipped or duplicated.
- Strobe: G_n=1 for 2 cycles with Ready=1. Required: `Valid`=0 and Ptr not advanced. On G_n=0, scan resumes at the held channel.
- Boundaries: CHANNELS=5, SEL_BITS=3. Load S=6 is ignored (Ptr unchanged). The scan wraps 4 to 0 with a `Wrap` pulse. Load together with Capture: `Chan` shows the old Ptr, then S.
- Mid-scan reset: assert Reset at `Chan`=4 with START=2. Required: `Valid`=0, `Out`=0, `Wrap`=0 after the edge. The first post-reset sample has `Chan`=2.
